imm_encode: RTL and testbench
=============================

# imm_encode

Immediate encoder and instruction assembler. It is the inverse of the core's immediate-extension stage: it takes an instruction template plus a 32-bit immediate and packs the immediate into the I/S/B/U/J bit positions. It also expands the load-immediate (LI) pseudo-op into a LUI+ADDI pair. It sits between the self-test/boot sequencer and instruction memory, with valid/ready on both sides and one registered output stage.

## Interface
- DATA_WIDTH, 32, instruction/immediate width. Only 32 is supported.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o.
- ImmSrc_i  in  3  format select:
  - 000 I, 001 S, 010 B, 011 U, 100 J.
  - 101 LI pseudo-op.
  - 110/111 reserved.
- base_i  in  DATA_WIDTH  instruction template; immediate bit positions are ignored. For LI, only rd = base_i[11:7] is used.
- imm_i  in  DATA_WIDTH  signed immediate (U: full value, low 12 bits expected zero).
- out_valid_o  out  1  instr_o valid.
- out_ready_i  in  1  downstream accepts when out_valid_o && out_ready_i.
- instr_o  out  DATA_WIDTH  encoded instruction.
- err_o  out  1  immediate not representable / reserved ImmSrc. Qualified by out_valid_o.
- last_o  out  1  final word of the request. Always 1 except for the LUI word of a two-word LI.

## Operation
**Field packing:** non-immediate bits are taken from base_i.
- I: [31:20]=imm[11:0].
- S: [31:25]=imm[11:5], [11:7]=imm[4:0].
- B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
- U: [31:12]=imm[31:12].
- J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].

**Error checks:** err_o=1 if any check fails. The word is still emitted with the truncated fields.
- I/S: -2048 ≤ imm ≤ 2047.
- B: -4096 ≤ imm ≤ 4094 and imm[0]=0.
- J: -2^20 ≤ imm ≤ 2^20-2 and imm[0]=0.
- U: imm[11:0]=0.
- Reserved ImmSrc: instr_o=base_i, err_o=1, last_o=1.

**LI expansion:**
- lo = imm[11:0] (sign-extended on decode).
- hi = imm[31:12] + imm[11], 20-bit wrap, no error.
- If hi==0: emit one word, ADDI rd,x0,lo = {lo,5'd0,3'b000,rd,7'b0010011}, last_o=1.
- Otherwise emit two words:
  - LUI rd,hi = {hi,rd,7'b0110111}, last_o=0.
  - Then ADDI rd,rd,lo = {lo,rd,3'b000,rd,7'b0010011}, last_o=1.
- LI never sets err_o.

**State machine:**
- EMPTY: no output held.
- FULL: a single word or the final word is held.
- PEND: LUI is held and the ADDI is latched internally.
- Transitions:
  - EMPTY → accept → FULL (single word) or PEND (two-word LI).
  - FULL, out handshake, no accept → EMPTY.
  - FULL, out handshake with simultaneous accept → FULL or PEND, depending on the new request.
  - PEND, out handshake → FULL (ADDI presented).
- in_ready_o = (state==EMPTY) || (state==FULL && out_ready_i). in_ready_o is 0 in PEND.
- The combinational out_ready_i→in_ready_o path is permitted.

## Timing
- Reset (async assert, release synchronised to clk_i): state EMPTY, out_valid_o=0, instr_o=0, err_o=0, last_o=0. in_ready_o=1 after reset.
- Latency: out_valid_o rises the cycle after the accepting edge. Throughput is 1 word/cycle with out_ready_i held high.
- Two-word LI occupies 2 output beats and blocks input for at least 1 extra cycle.
- instr_o, err_o and last_o are stable while out_valid_o && !out_ready_i.
- Reset asserted in PEND discards the pending ADDI. No word is emitted after reset.
- in_valid_i with in_ready_o=0: the input is ignored. The source must hold it.

## Test plan
- I: base=0x00000093, imm=-1, ImmSrc=000 → instr_o=0xFFF00093, err_o=0, last_o=1, one cycle after accept.
- B: base=0x00000063, imm=-4, ImmSrc=010 → 0xFE000EE3, err_o=0. Same with imm=3 → err_o=1.
- LI two-word: base rd=5 (0x00000280), imm=0x12345FFF, ImmSrc=101 → 0x123462B7 with last_o=0, then 0xFFF28293 with last_o=1. in_ready_o=0 while the LUI is held.
- LI one-word: rd=5, imm=0x000007FF → single 0x7FF00293, last_o=1.
- Backpressure: hold out_ready_i=0 for 3 cycles mid-LI → LUI word stable, no accepts. Release → ADDI on the next beat. Back-to-back single words then stream at 1/cycle.
- Reset asserted in PEND → out_valid_o=0 immediately. After release, the next request's word is emitted with no stale ADDI.
- Random round-trip check: for err_o=0 words, the immediate decoded from instr_o for that ImmSrc must equal imm_i.

Source files
------------

// File: rtl/imm_encode_if.sv
// Handshake bundle for imm_encode: template/immediate request in, encoded instruction out.
// The slave view belongs to the encoder; the master view belongs to the sequencer/memory side.
interface imm_encode_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [2:0]            ImmSrc_i;
  logic [DATA_WIDTH-1:0] base_i;
  logic [DATA_WIDTH-1:0] imm_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic                  err_o;
  logic                  last_o;

  modport slave (
    input  in_valid_i, ImmSrc_i, base_i, imm_i, out_ready_i,
    output in_ready_o, out_valid_o, instr_o, err_o, last_o
  );

  modport master (
    output in_valid_i, ImmSrc_i, base_i, imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, err_o, last_o
  );
endinterface

// File: rtl/imm_encode.sv
// Immediate encoder: packs a 32-bit immediate into I/S/B/U/J fields of a template and
// expands LI into LUI+ADDI, behind a single registered output stage.
module imm_encode #(
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  imm_encode_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    PEND  = 2'd2
  } state_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] SRC_I  = 3'b000;
  localparam logic [2:0] SRC_S  = 3'b001;
  localparam logic [2:0] SRC_B  = 3'b010;
  localparam logic [2:0] SRC_U  = 3'b011;
  localparam logic [2:0] SRC_J  = 3'b100;
  localparam logic [2:0] SRC_LI = 3'b101;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic                  err_q, err_d;
  logic                  last_q, last_d;

  logic [DATA_WIDTH-1:0] enc_instr, enc_addi;
  logic                  enc_err, enc_last, enc_two;
  logic [11:0]           li_lo;
  logic [19:0]           li_hi;
  logic [4:0]            rd;
  logic                  in_ready, out_valid, accept, out_hs;

  // Encoder for the request currently on the input side.
  always_comb begin
    // NOTE: every combinational output is given a default first, so no path infers a latch.
    enc_instr = bus.base_i;
    enc_addi  = '0;
    enc_err   = 1'b0;
    enc_last  = 1'b1;
    enc_two   = 1'b0;
    rd        = bus.base_i[11:7];
    li_lo     = bus.imm_i[11:0];
    li_hi     = bus.imm_i[31:12] + {19'd0, bus.imm_i[11]};

    case (bus.ImmSrc_i)
      SRC_I: begin
        enc_instr = {bus.imm_i[11:0], bus.base_i[19:0]};
        enc_err   = bus.imm_i[31:11] != {21{bus.imm_i[11]}};
      end
      SRC_S: begin
        enc_instr = {bus.imm_i[11:5], bus.base_i[24:12], bus.imm_i[4:0], bus.base_i[6:0]};
        enc_err   = bus.imm_i[31:11] != {21{bus.imm_i[11]}};
      end
      SRC_B: begin
        enc_instr = {bus.imm_i[12], bus.imm_i[10:5], bus.base_i[24:12],
                     bus.imm_i[4:1], bus.imm_i[11], bus.base_i[6:0]};
        enc_err   = (bus.imm_i[31:12] != {20{bus.imm_i[12]}}) || bus.imm_i[0];
      end
      SRC_U: begin
        enc_instr = {bus.imm_i[31:12], bus.base_i[11:0]};
        enc_err   = |bus.imm_i[11:0];
      end
      SRC_J: begin
        enc_instr = {bus.imm_i[20], bus.imm_i[10:1], bus.imm_i[11],
                     bus.imm_i[19:12], bus.base_i[11:0]};
        enc_err   = (bus.imm_i[31:20] != {12{bus.imm_i[20]}}) || bus.imm_i[0];
      end
      SRC_LI: begin
        // hi absorbs the borrow that sign-extending lo will cause in the ADDI.
        if (li_hi == 20'd0) begin
          enc_instr = {li_lo, 5'd0, 3'b000, rd, OP_IMM};
        end else begin
          enc_instr = {li_hi, rd, OP_LUI};
          enc_addi  = {li_lo, rd, 3'b000, rd, OP_IMM};
          enc_last  = 1'b0;
          enc_two   = 1'b1;
        end
      end
      default: enc_err = 1'b1;
    endcase
  end

  // Output-side control.
  always_comb begin
    in_ready  = (state_q == EMPTY) || ((state_q == FULL) && bus.out_ready_i);
    out_valid = state_q != EMPTY;
    accept    = bus.in_valid_i && in_ready;
    out_hs    = out_valid && bus.out_ready_i;
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.instr_o     = instr_q;
  assign bus.err_o       = err_q;
  assign bus.last_o      = last_q;

  // Next state and next output word.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    err_d   = err_q;
    last_d  = last_q;
    pend_d  = pend_q;

    case (state_q)
      FULL: if (out_hs) state_d = EMPTY;
      PEND: begin
        if (out_hs) begin
          state_d = FULL;
          instr_d = pend_q;
          err_d   = 1'b0;
          last_d  = 1'b1;
        end
      end
      EMPTY:   state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    // Accept only happens from EMPTY or from FULL while the held word drains.
    if (accept) begin
      state_d = enc_two ? PEND : FULL;
      instr_d = enc_instr;
      err_d   = enc_err;
      last_d  = enc_last;
      pend_d  = enc_addi;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the latched ADDI is cleared as well, so nothing stale can surface after reset.
      state_q <= EMPTY;
      instr_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_imm_encode.sv
// Scoreboarded bench for imm_encode: an independent encoder model fills the queue on accept,
// a monitor pops it on every output handshake and also decodes immediates back.
module tb_imm_encode;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic        last;
    logic [2:0]  src;
    logic [31:0] imm;
    logic        rt;
  } exp_t;

  logic clk_i     = 1'b0;
  logic rst_ni    = 1'b0;
  logic tb_ready  = 1'b1;
  logic rnd_ready = 1'b1;
  logic rand_bp   = 1'b0;
  int   errors    = 0;
  int   checks    = 0;
  int   cyc       = 0;
  exp_t sb[$];

  imm_encode_if bus ();

  assign bus.out_ready_i = rand_bp ? rnd_ready : tb_ready;

  imm_encode dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(posedge clk_i) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Reference encoder written arithmetically rather than as bit concatenations.
  function automatic void model(input logic [2:0] src, input logic [31:0] base,
                                input logic [31:0] imm, output exp_t w0, output exp_t w1,
                                output bit two);
    int          v;
    logic [31:0] hi, lo, rd;
    v  = imm;
    lo = 32'(imm[11:0]);
    rd = 32'(base[11:7]);
    hi = (imm + 32'h800) >> 12;
    w0 = '{instr: base, err: 1'b0, last: 1'b1, src: src, imm: imm, rt: (src <= 3'd4)};
    w1 = w0;
    two = 1'b0;
    case (src)
      3'd0: begin
        w0.instr = (base & 32'h000F_FFFF) | (lo << 20);
        w0.err   = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        w0.instr = (base & 32'h01FF_F07F) | (32'(imm[11:5]) << 25) | (32'(imm[4:0]) << 7);
        w0.err   = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        w0.instr = (base & 32'h01FF_F07F) | (32'(imm[12]) << 31) | (32'(imm[10:5]) << 25)
                 | (32'(imm[4:1]) << 8) | (32'(imm[11]) << 7);
        w0.err   = (v < -4096) || (v > 4094) || imm[0];
      end
      3'd3: begin
        w0.instr = (base & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
        w0.err   = (imm & 32'hFFF) != 0;
      end
      3'd4: begin
        w0.instr = (base & 32'h0000_0FFF) | (32'(imm[20]) << 31) | (32'(imm[10:1]) << 21)
                 | (32'(imm[11]) << 20) | (32'(imm[19:12]) << 12);
        w0.err   = (v < -1048576) || (v > 1048574) || imm[0];
      end
      3'd5: begin
        if (hi == 0) begin
          w0.instr = (lo << 20) | (rd << 7) | 32'h13;
        end else begin
          two      = 1'b1;
          w0.instr = (hi << 12) | (rd << 7) | 32'h37;
          w0.last  = 1'b0;
          w1.instr = (lo << 20) | (rd << 15) | (rd << 7) | 32'h13;
        end
      end
      default: w0.err = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] decode(input logic [2:0] src, input logic [31:0] w);
    case (src)
      3'd0:    return {{20{w[31]}}, w[31:20]};
      3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {w[31:12], 12'd0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  // Monitor: scoreboard pops, hold-stability under backpressure, immediate round trip.
  logic [33:0] held_word;
  logic        held = 1'b0;
  always @(negedge clk_i) begin
    exp_t        e;
    logic [31:0] dec;
    if (!rst_ni) begin
      held = 1'b0;
    end else begin
      if (held && bus.out_valid_o) begin
        checks++;
        if ({bus.instr_o, bus.err_o, bus.last_o} !== held_word) begin
          errors++;
          $display("FAIL stable: got %h required %h", {bus.instr_o, bus.err_o, bus.last_o}, held_word);
        end
      end
      held      = bus.out_valid_o && !bus.out_ready_i;
      held_word = {bus.instr_o, bus.err_o, bus.last_o};
      if (bus.out_valid_o && bus.out_ready_i) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got instr=%h err=%b last=%b, required no word",
                   bus.instr_o, bus.err_o, bus.last_o);
        end else begin
          e = sb.pop_front();
          if (bus.instr_o !== e.instr || bus.err_o !== e.err || bus.last_o !== e.last) begin
            errors++;
            $display("FAIL word src=%0d imm=%h: got instr=%h err=%b last=%b required instr=%h err=%b last=%b",
                     e.src, e.imm, bus.instr_o, bus.err_o, bus.last_o, e.instr, e.err, e.last);
          end
          if (e.rt && !e.err && bus.err_o === 1'b0) begin
            checks++;
            dec = decode(e.src, bus.instr_o);
            if (dec !== e.imm) begin
              errors++;
              $display("FAIL roundtrip src=%0d: got imm=%h required %h", e.src, dec, e.imm);
            end
          end
        end
      end
    end
  end

  // Drive a request, wait for acceptance, push expected words. Starts/ends at posedge+1.
  task automatic send(input logic [2:0] src, input logic [31:0] base, input logic [31:0] imm,
                      input bit keep);
    exp_t w0, w1;
    bit   two;
    bit   done = 1'b0;
    model(src, base, imm, w0, w1, two);
    bus.in_valid_i = 1'b1;
    bus.ImmSrc_i   = src;
    bus.base_i     = base;
    bus.imm_i      = imm;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (bus.in_ready_o === 1'b1) begin
        sb.push_back(w0);
        if (two) sb.push_back(w1);
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout src=%0d imm=%h: got no accept, required accept", src, imm);
    end
    @(posedge clk_i);
    #1;
    if (!keep) bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk_i);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d words outstanding, required 0", sb.size());
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.instr_o !== 32'h0 || bus.err_o !== 1'b0 ||
        bus.last_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b instr=%h err=%b last=%b rdy=%b required 0 0 0 0 1",
               bus.out_valid_o, bus.instr_o, bus.err_o, bus.last_o, bus.in_ready_o);
    end
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_i_latency();
    tb_ready = 1'b1;
    send(3'd0, 32'h0000_0093, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.instr_o !== 32'hFFF0_0093 ||
        bus.err_o !== 1'b0 || bus.last_o !== 1'b1) begin
      errors++;
      $display("FAIL i_latency: got v=%b instr=%h err=%b last=%b required 1 fff00093 0 1",
               bus.out_valid_o, bus.instr_o, bus.err_o, bus.last_o);
    end
    wait_drain();
  endtask

  task automatic test_b();
    send(3'd2, 32'h0000_0063, 32'hFFFF_FFFC, 1'b0);
    checks++;
    if (bus.instr_o !== 32'hFE00_0EE3 || bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL b_neg4: got instr=%h err=%b required fe000ee3 0", bus.instr_o, bus.err_o);
    end
    send(3'd2, 32'h0000_0063, 32'h0000_0003, 1'b0);
    checks++;
    if (bus.err_o !== 1'b1) begin
      errors++;
      $display("FAIL b_odd: got err=%b required 1", bus.err_o);
    end
    wait_drain();
  endtask

  task automatic test_formats();
    logic [2:0]  srcs [21] = '{2, 2, 2, 0, 0, 0, 0, 1, 1, 1, 3, 3, 4, 4, 4, 4, 4, 6, 7, 2, 1};
    logic [31:0] bases[21] = '{32'h63, 32'h63, 32'h63, 32'h93, 32'h93, 32'h93, 32'h93,
                               32'h23, 32'h23, 32'hFFFF_FFFF, 32'h37, 32'h37, 32'h6F, 32'h6F,
                               32'h6F, 32'h6F, 32'h6F, 32'hDEAD_BEEF, 32'h1234_5678,
                               32'hFFFF_FFFF, 32'h23};
    int          imms [21] = '{4094, 4096, -4096, 2047, 2048, -2048, -2049, -2048, 2047, 5,
                               32'h1234_5000, 32'h1234_5001, 1048574, -1048576, 1048576, 6, 7,
                               5, 0, -4098, -2049};
    for (int i = 0; i < 21; i++) send(srcs[i], bases[i], imms[i], 1'b1);
    bus.in_valid_i = 1'b0;
    wait_drain();
  endtask

  task automatic test_li();
    send(3'd5, 32'h0000_0280, 32'h1234_5FFF, 1'b0);
    checks++;
    if (bus.instr_o !== 32'h1234_62B7 || bus.last_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL li_lui: got instr=%h last=%b rdy=%b required 123462b7 0 0",
               bus.instr_o, bus.last_o, bus.in_ready_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.instr_o !== 32'hFFF2_8293 || bus.last_o !== 1'b1) begin
      errors++;
      $display("FAIL li_addi: got v=%b instr=%h last=%b required 1 fff28293 1",
               bus.out_valid_o, bus.instr_o, bus.last_o);
    end
    wait_drain();
    send(3'd5, 32'h0000_0280, 32'h0000_07FF, 1'b0);
    checks++;
    if (bus.instr_o !== 32'h7FF0_0293 || bus.last_o !== 1'b1 || bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL li_one: got instr=%h last=%b err=%b required 7ff00293 1 0",
               bus.instr_o, bus.last_o, bus.err_o);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    tb_ready = 1'b0;
    send(3'd5, 32'h0000_0280, 32'h1234_5FFF, 1'b0);
    bus.in_valid_i = 1'b1;
    bus.ImmSrc_i   = 3'd0;
    bus.base_i     = 32'h0000_0013;
    bus.imm_i      = 32'd100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.instr_o !== 32'h1234_62B7 || bus.in_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got v=%b instr=%h rdy=%b required 1 123462b7 0",
                 i, bus.out_valid_o, bus.instr_o, bus.in_ready_o);
      end
    end
    @(posedge clk_i);
    #1 tb_ready = 1'b1;
    send(3'd0, 32'h0000_0013, 32'd100, 1'b0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int start;
    tb_ready = 1'b1;
    start = cyc;
    for (int i = 0; i < 6; i++) send(3'(i % 2), $urandom, 32'(i * 37) - 32'd100, 1'b1);
    bus.in_valid_i = 1'b0;
    checks++;
    if (cyc - start != 6) begin
      errors++;
      $display("FAIL throughput: got %0d cycles for 6 words, required 6", cyc - start);
    end
    wait_drain();
  endtask

  task automatic test_reset_pend();
    tb_ready = 1'b0;
    send(3'd5, 32'h0000_0280, 32'h1234_5FFF, 1'b0);
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.last_o !== 1'b0) begin
      errors++;
      $display("FAIL pend_entry: got v=%b last=%b required 1 0", bus.out_valid_o, bus.last_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.instr_o !== 32'h0) begin
      errors++;
      $display("FAIL pend_reset: got v=%b instr=%h required 0 00000000", bus.out_valid_o, bus.instr_o);
    end
    sb.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1 tb_ready = 1'b1;
    send(3'd0, 32'h0000_0093, 32'h0000_0001, 1'b0);
    wait_drain();
    repeat (5) @(posedge clk_i);
    #1;
  endtask

  task automatic test_random();
    logic [2:0]  src;
    logic [31:0] imm;
    rand_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      src = 3'($urandom_range(0, 7));
      case (src)
        3'd0, 3'd1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        3'd2:       imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
        3'd3:       imm = $urandom & 32'hFFFF_F000;
        3'd4:       imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
        default:    imm = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) imm = $urandom;
      send(src, $urandom, imm, 1'b1);
    end
    bus.in_valid_i = 1'b0;
    wait_drain();
    rand_bp = 1'b0;
  endtask

  initial begin
    bus.in_valid_i = 1'b0;
    bus.ImmSrc_i   = 3'd0;
    bus.base_i     = 32'h0;
    bus.imm_i      = 32'h0;
    test_reset();
    test_i_latency();
    test_b();
    test_formats();
    test_li();
    test_backpressure();
    test_back_to_back();
    test_reset_pend();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
